// File: rtl/div_issue_writeback_ctrl.sv
// Issue and writeback wrapper around a fixed-latency, in-order pipelined divider:
// tags in-flight ops, picks quotient/remainder and buffers results under a credit limit.
module div_issue_writeback_ctrl #(
    parameter int WIDTH        = 32,
    parameter int RESULT_DEPTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_issue_valid,
    output logic             o_issue_ready,
    input  logic [1:0]       i_issue_op,
    input  logic [4:0]       i_issue_rd,
    input  logic [WIDTH-1:0] i_issue_dividend,
    input  logic [WIDTH-1:0] i_issue_divisor,
    input  logic             i_flush,
    output logic             o_div_valid,
    output logic             o_div_is_signed,
    output logic [WIDTH-1:0] o_div_dividend,
    output logic [WIDTH-1:0] o_div_divisor,
    input  logic             i_div_valid,
    input  logic [WIDTH-1:0] i_div_quotient,
    input  logic [WIDTH-1:0] i_div_remainder,
    output logic             o_wb_valid,
    input  logic             i_wb_ready,
    output logic [4:0]       o_wb_rd,
    output logic [WIDTH-1:0] o_wb_data,
    output logic             o_protocol_error
);
    localparam int AW = $clog2(RESULT_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] CREDIT_MAX = (CW+1)'(RESULT_DEPTH);

    logic [AW-1:0]    tag_wr_ptr, tag_rd_ptr;
    logic [CW-1:0]    tag_cnt;
    logic             tag_rem_mem  [RESULT_DEPTH];
    logic [4:0]       tag_rd_mem   [RESULT_DEPTH];
    logic             tag_kill_mem [RESULT_DEPTH];

    logic [AW-1:0]    res_wr_ptr, res_rd_ptr;
    logic [CW-1:0]    res_cnt;
    logic [4:0]       res_rd_mem   [RESULT_DEPTH];
    logic [WIDTH-1:0] res_data_mem [RESULT_DEPTH];

    logic [CW:0]      credit_used;
    logic             accept, tag_pop, res_push, res_pop, err_set;
    logic [WIDTH-1:0] ret_data;

    function automatic logic [WIDTH-1:0] select_result(input logic             is_rem,
                                                       input logic [WIDTH-1:0] quo,
                                                       input logic [WIDTH-1:0] rem);
        return is_rem ? rem : quo;
    endfunction

    // Issue stage: zero-latency pass-through gated by credits
    always_comb begin
        credit_used   = {1'b0, tag_cnt} + {1'b0, res_cnt};
        o_issue_ready = ~i_rst & ~i_flush & (credit_used < CREDIT_MAX);
        accept        = i_issue_valid & o_issue_ready;
        tag_pop       = i_div_valid & (tag_cnt != '0);
        err_set       = i_div_valid & (tag_cnt == '0);
        res_push      = tag_pop & ~tag_kill_mem[tag_rd_ptr] & ~i_flush;
        o_wb_valid    = (res_cnt != '0) & ~i_flush;
        res_pop       = o_wb_valid & i_wb_ready;
        ret_data      = select_result(tag_rem_mem[tag_rd_ptr], i_div_quotient, i_div_remainder);
    end

    assign o_div_valid     = accept;
    assign o_div_is_signed = ~i_issue_op[0];
    assign o_div_dividend  = i_issue_dividend;
    assign o_div_divisor   = i_issue_divisor;
    assign o_wb_rd         = res_rd_mem[res_rd_ptr];
    assign o_wb_data       = res_data_mem[res_rd_ptr];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tag_wr_ptr       <= '0;
            tag_rd_ptr       <= '0;
            tag_cnt          <= '0;
            res_wr_ptr       <= '0;
            res_rd_ptr       <= '0;
            res_cnt          <= '0;
            o_protocol_error <= 1'b0;
        end else begin
            if (accept)  tag_wr_ptr <= tag_wr_ptr + AW'(1);
            if (tag_pop) tag_rd_ptr <= tag_rd_ptr + AW'(1);
            tag_cnt <= tag_cnt + CW'(accept) - CW'(tag_pop);
            // Flush empties the result FIFO; nothing can push or pop that cycle
            if (i_flush) begin
                res_rd_ptr <= res_wr_ptr;
                res_cnt    <= '0;
            end else begin
                if (res_push) res_wr_ptr <= res_wr_ptr + AW'(1);
                if (res_pop)  res_rd_ptr <= res_rd_ptr + AW'(1);
                res_cnt <= res_cnt + CW'(res_push) - CW'(res_pop);
            end
            if (err_set) o_protocol_error <= 1'b1;
        end
    end

    // Writeback stage: tag metadata and result storage (no reset needed)
    always_ff @(posedge i_clk) begin
        if (accept) begin
            tag_rem_mem[tag_wr_ptr] <= i_issue_op[1];
            tag_rd_mem[tag_wr_ptr]  <= i_issue_rd;
        end
        for (int i = 0; i < RESULT_DEPTH; i++) begin
            if (i_flush)
                tag_kill_mem[i] <= 1'b1;
            else if (accept && (tag_wr_ptr == AW'(i)))
                tag_kill_mem[i] <= 1'b0;
        end
        if (res_push) begin
            res_rd_mem[res_wr_ptr]   <= tag_rd_mem[tag_rd_ptr];
            res_data_mem[res_wr_ptr] <= ret_data;
        end
    end
endmodule

// File: tb/tb_div_issue_writeback_ctrl.sv
// Bench for div_issue_writeback_ctrl: emulates the 17-cycle divider, runs directed
// vectors and corner sequences, then random traffic against a queue-based model.
module tb_div_issue_writeback_ctrl;
    localparam int W = 32;
    localparam int D = 8;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_issue_valid, o_issue_ready;
    logic [1:0]    i_issue_op;
    logic [4:0]    i_issue_rd;
    logic [W-1:0]  i_issue_dividend, i_issue_divisor;
    logic          i_flush;
    logic          o_div_valid, o_div_is_signed;
    logic [W-1:0]  o_div_dividend, o_div_divisor;
    logic          i_div_valid;
    logic [W-1:0]  i_div_quotient, i_div_remainder;
    logic          o_wb_valid, i_wb_ready;
    logic [4:0]    o_wb_rd;
    logic [W-1:0]  o_wb_data;
    logic          o_protocol_error;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 i_clk = ~i_clk;

    div_issue_writeback_ctrl #(.WIDTH(W), .RESULT_DEPTH(D)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_issue_valid(i_issue_valid), .o_issue_ready(o_issue_ready),
        .i_issue_op(i_issue_op), .i_issue_rd(i_issue_rd),
        .i_issue_dividend(i_issue_dividend), .i_issue_divisor(i_issue_divisor),
        .i_flush(i_flush),
        .o_div_valid(o_div_valid), .o_div_is_signed(o_div_is_signed),
        .o_div_dividend(o_div_dividend), .o_div_divisor(o_div_divisor),
        .i_div_valid(i_div_valid), .i_div_quotient(i_div_quotient),
        .i_div_remainder(i_div_remainder),
        .o_wb_valid(o_wb_valid), .i_wb_ready(i_wb_ready),
        .o_wb_rd(o_wb_rd), .o_wb_data(o_wb_data),
        .o_protocol_error(o_protocol_error)
    );

    // RISC-V M-extension division semantics
    function automatic logic [W-1:0] ref_quo(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == '0) return '1;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        if (sgn) return W'($signed(a) / $signed(b));
        return a / b;
    endfunction

    function automatic logic [W-1:0] ref_rem(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == '0) return a;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return '0;
        if (sgn) return W'($signed(a) % $signed(b));
        return a % b;
    endfunction

    // Divider emulator: 17 cycles from acceptance to output, reset by the shared reset
    logic         pv [17];
    logic [W-1:0] pq [17];
    logic [W-1:0] pr [17];
    logic         force_div;

    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < 17; i++) pv[i] <= 1'b0;
        end else begin
            pv[0] <= o_div_valid;
            pq[0] <= ref_quo(o_div_is_signed, o_div_dividend, o_div_divisor);
            pr[0] <= ref_rem(o_div_is_signed, o_div_dividend, o_div_divisor);
            for (int i = 1; i < 17; i++) begin
                pv[i] <= pv[i-1];
                pq[i] <= pq[i-1];
                pr[i] <= pr[i-1];
            end
        end
    end

    assign i_div_valid     = pv[16] | force_div;
    assign i_div_quotient  = pq[16];
    assign i_div_remainder = pr[16];

    function automatic void chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_issue(input logic v, input logic [1:0] op, input logic [4:0] rd,
                             input logic [W-1:0] a, input logic [W-1:0] b);
        i_issue_valid    = v;
        i_issue_op       = op;
        i_issue_rd       = rd;
        i_issue_dividend = a;
        i_issue_divisor  = b;
    endtask

    typedef struct {
        logic [1:0]   op;
        logic [4:0]   rd;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
    } vec_t;

    typedef struct {
        logic [4:0]   rd;
        logic [W-1:0] data;
        int           t;
        bit           killed;
    } rec_t;

    task automatic run_random(input int cycles);
        rec_t         mq[$];
        rec_t         keep[$];
        logic         exp_rdy, exp_wbv;
        int           idx;
        logic [W-1:0] a, b;
        for (int c = 0; c < cycles; c++) begin
            while (mq.size() > 0 && mq[0].killed && mq[0].t + 17 < c) void'(mq.pop_front());
            case ($urandom_range(0, 3))
                0: a = 32'h8000_0000;
                1: a = $urandom_range(0, 50);
                default: a = $urandom();
            endcase
            case ($urandom_range(0, 4))
                0: b = '0;
                1: b = 32'hFFFF_FFFF;
                2: b = $urandom_range(1, 9);
                default: b = $urandom();
            endcase
            set_issue($urandom_range(0, 9) < 6, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), a, b);
            i_flush    = ($urandom_range(0, 99) < 3);
            i_wb_ready = ($urandom_range(0, 9) < 7);
            #1;
            exp_rdy = !i_flush && (mq.size() < D);
            idx = -1;
            for (int i = 0; i < mq.size(); i++) begin
                if (!mq[i].killed) begin
                    idx = i;
                    break;
                end
            end
            exp_wbv = !i_flush && idx >= 0 && (mq[idx].t + 18 <= c);
            chk("rnd_issue_ready", o_issue_ready, exp_rdy);
            chk("rnd_div_valid", o_div_valid, i_issue_valid & exp_rdy);
            chk("rnd_is_signed", o_div_is_signed, !i_issue_op[0]);
            chk("rnd_wb_valid", o_wb_valid, exp_wbv);
            if (exp_wbv) begin
                chk("rnd_wb_rd", o_wb_rd, mq[idx].rd);
                chk("rnd_wb_data", o_wb_data, mq[idx].data);
            end
            if (i_flush) begin
                keep.delete();
                foreach (mq[i]) begin
                    if (mq[i].killed || mq[i].t + 18 > c) begin
                        mq[i].killed = 1'b1;
                        keep.push_back(mq[i]);
                    end
                end
                mq = keep;
            end else if (exp_wbv && i_wb_ready) begin
                mq.delete(idx);
            end
            if (i_issue_valid && exp_rdy)
                mq.push_back('{i_issue_rd,
                               i_issue_op[1] ? ref_rem(!i_issue_op[0], a, b) : ref_quo(!i_issue_op[0], a, b),
                               c, 1'b0});
            tick();
        end
        set_issue(1'b0, 2'd0, 5'd0, '0, '0);
        i_flush = 1'b0;
    endtask

    initial begin
        vec_t         vt[13];
        logic [4:0]   exp_rd[$];
        int           got;

        vt[0]  = '{2'd0, 5'd1,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD};
        vt[1]  = '{2'd2, 5'd2,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF};
        vt[2]  = '{2'd1, 5'd3,  32'd5,         32'd0,         32'hFFFF_FFFF};
        vt[3]  = '{2'd3, 5'd4,  32'd5,         32'd0,         32'h0000_0005};
        vt[4]  = '{2'd0, 5'd5,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        vt[5]  = '{2'd2, 5'd6,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
        vt[6]  = '{2'd1, 5'd7,  32'd100,       32'd7,         32'd14};
        vt[7]  = '{2'd3, 5'd8,  32'd100,       32'd7,         32'd2};
        vt[8]  = '{2'd0, 5'd9,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD};
        vt[9]  = '{2'd2, 5'd10, 32'd7,         32'hFFFF_FFFE, 32'd1};
        vt[10] = '{2'd0, 5'd11, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF};
        vt[11] = '{2'd2, 5'd31, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB};
        vt[12] = '{2'd1, 5'd0,  32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC};

        i_rst = 1'b1;
        set_issue(1'b0, 2'd0, 5'd0, '0, '0);
        i_flush = 1'b0;
        i_wb_ready = 1'b0;
        force_div = 1'b0;
        #1;
        chk("rst_issue_ready", o_issue_ready, 1'b0);
        chk("rst_wb_valid", o_wb_valid, 1'b0);
        chk("rst_protocol_error", o_protocol_error, 1'b0);
        tick();
        tick();
        i_rst = 1'b0;
        #1;
        chk("post_rst_issue_ready", o_issue_ready, 1'b1);

        // Directed vectors, one op at a time, result expected exactly 18 cycles later
        i_wb_ready = 1'b1;
        foreach (vt[k]) begin
            set_issue(1'b1, vt[k].op, vt[k].rd, vt[k].a, vt[k].b);
            #1;
            chk("vec_issue_ready", o_issue_ready, 1'b1);
            chk("vec_is_signed", o_div_is_signed, !vt[k].op[0]);
            chk("vec_div_dividend", o_div_dividend, vt[k].a);
            tick();
            i_issue_valid = 1'b0;
            repeat (16) tick();
            chk("vec_wb_early", o_wb_valid, 1'b0);
            tick();
            chk("vec_wb_valid", o_wb_valid, 1'b1);
            chk("vec_wb_rd", o_wb_rd, vt[k].rd);
            chk("vec_wb_data", o_wb_data, vt[k].exp);
        end
        tick();

        // Back-to-back DIVU/REMU by zero
        set_issue(1'b1, 2'd1, 5'd3, 32'd5, 32'd0);
        tick();
        set_issue(1'b1, 2'd3, 5'd4, 32'd5, 32'd0);
        tick();
        i_issue_valid = 1'b0;
        repeat (16) tick();
        chk("b2b_valid0", o_wb_valid, 1'b1);
        chk("b2b_rd0", o_wb_rd, 5'd3);
        chk("b2b_data0", o_wb_data, 32'hFFFF_FFFF);
        tick();
        chk("b2b_valid1", o_wb_valid, 1'b1);
        chk("b2b_rd1", o_wb_rd, 5'd4);
        chk("b2b_data1", o_wb_data, 32'h0000_0005);
        tick();
        chk("b2b_empty", o_wb_valid, 1'b0);

        // Backpressure: eight ops fill all credits, ninth waits for the first pop
        i_wb_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            set_issue(1'b1, 2'd1, 5'(k + 8), 32'(100 + k), 32'd1);
            #1;
            chk("bp_issue_ready", o_issue_ready, 1'b1);
            tick();
        end
        set_issue(1'b1, 2'd1, 5'd20, 32'd55, 32'd5);
        #1;
        chk("bp_ninth_blocked", o_issue_ready, 1'b0);
        repeat (20) tick();
        for (int k = 0; k < 3; k++) begin
            chk("bp_hold_valid", o_wb_valid, 1'b1);
            chk("bp_hold_rd", o_wb_rd, 5'd8);
            chk("bp_hold_data", o_wb_data, 32'd100);
            chk("bp_hold_ready", o_issue_ready, 1'b0);
            tick();
        end
        i_wb_ready = 1'b1;
        #1;
        chk("bp_pop_cycle_ready", o_issue_ready, 1'b0);
        chk("bp_pop0_rd", o_wb_rd, 5'd8);
        tick();
        chk("bp_ready_returns", o_issue_ready, 1'b1);
        chk("bp_pop1_rd", o_wb_rd, 5'd9);
        chk("bp_pop1_data", o_wb_data, 32'd101);
        tick();
        i_issue_valid = 1'b0;
        for (int k = 10; k < 16; k++) exp_rd.push_back(5'(k));
        exp_rd.push_back(5'd20);
        got = 0;
        for (int k = 0; k < 40; k++) begin
            if (o_wb_valid) begin
                if (got < exp_rd.size()) chk("bp_drain_rd", o_wb_rd, exp_rd[got]);
                if (o_wb_rd == 5'd20) chk("bp_ninth_data", o_wb_data, 32'd11);
                got++;
            end
            tick();
        end
        chk("bp_drain_count", 32'(got), 32'd7);

        // Flush with three ops in flight, then one new op
        for (int k = 0; k < 3; k++) begin
            set_issue(1'b1, 2'd0, 5'(k + 1), 32'd40, 32'd4);
            tick();
        end
        i_issue_valid = 1'b0;
        repeat (4) tick();
        i_flush = 1'b1;
        set_issue(1'b1, 2'd1, 5'd17, 32'd9, 32'd3);
        #1;
        chk("flush_blocks_issue", o_issue_ready, 1'b0);
        tick();
        i_flush = 1'b0;
        #1;
        chk("post_flush_ready", o_issue_ready, 1'b1);
        tick();
        i_issue_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (k < 18) begin
                chk("flush_no_wb", o_wb_valid, 1'b0);
            end else if (k == 18) begin
                chk("flush_new_valid", o_wb_valid, 1'b1);
                chk("flush_new_rd", o_wb_rd, 5'd17);
                chk("flush_new_data", o_wb_data, 32'd3);
            end else begin
                chk("flush_after_new", o_wb_valid, 1'b0);
            end
            tick();
        end

        run_random(3000);
        repeat (30) tick();
        chk("rnd_no_protocol_error", o_protocol_error, 1'b0);
        chk("rnd_drained", o_wb_valid, 1'b0);

        // Divider output with nothing pending
        force_div = 1'b1;
        tick();
        force_div = 1'b0;
        chk("perr_set", o_protocol_error, 1'b1);
        chk("perr_dropped", o_wb_valid, 1'b0);
        repeat (5) tick();
        chk("perr_sticky", o_protocol_error, 1'b1);
        chk("perr_no_wb", o_wb_valid, 1'b0);

        // Asynchronous reset with buffered results
        i_wb_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_issue(1'b1, 2'd1, 5'(k + 1), 32'd8, 32'd2);
            tick();
        end
        i_issue_valid = 1'b0;
        repeat (20) tick();
        chk("prerst_wb_valid", o_wb_valid, 1'b1);
        #2;
        i_rst = 1'b1;
        #1;
        chk("midrst_wb_valid", o_wb_valid, 1'b0);
        chk("midrst_issue_ready", o_issue_ready, 1'b0);
        chk("midrst_perr_clear", o_protocol_error, 1'b0);
        tick();
        i_rst = 1'b0;
        #1;
        for (int k = 0; k < 8; k++) begin
            set_issue(1'b1, 2'd3, 5'(k), 32'(k), 32'd3);
            #1;
            chk("postrst_credit", o_issue_ready, 1'b1);
            tick();
        end
        set_issue(1'b1, 2'd3, 5'd9, 32'd9, 32'd3);
        #1;
        chk("postrst_full", o_issue_ready, 1'b0);
        i_issue_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
